// File: rtl/rfdc_dds_phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// rfdc_dds_phase_scheduler_if
// Bundles the timed-command channel and the phase stream of the DDS phase
// scheduler.
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. The source holds every cmd_* field stable while
// cmd_valid is high and cmd_ready is low. The phase stream has no back-pressure:
// once m_axis_phase_tvalid rises, a new word is presented every clock.
//
// Signals
//   cmd_timestamp       TS_W           apply time of command
//   cmd_freq            PHASE_W        phase step per sample
//   cmd_phase           PHASE_W        start phase of lane 0
//   cmd_amp/cmd_offset  14             scaler settings for this profile
//   cmd_valid/cmd_ready 1              command handshake
//   m_axis_phase_tdata  LANES*PHASE_W  lane i in [PHASE_W*i +: PHASE_W]
//   m_axis_phase_tvalid 1              phase stream valid
//   amp_out/offset_out  14             settings aligned with tdata
// Modports
//   master : command source / phase-stream consumer side
//   slave  : scheduler side
// ---------------------------------------------------------------------------
interface rfdc_dds_phase_scheduler_if #(
    parameter int LANES   = 16,
    parameter int PHASE_W = 40,
    parameter int TS_W    = 64
);
    logic [TS_W-1:0]          cmd_timestamp;
    logic [PHASE_W-1:0]       cmd_freq;
    logic [PHASE_W-1:0]       cmd_phase;
    logic [13:0]              cmd_amp;
    logic [13:0]              cmd_offset;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [LANES*PHASE_W-1:0] m_axis_phase_tdata;
    logic                     m_axis_phase_tvalid;
    logic [13:0]              amp_out;
    logic [13:0]              offset_out;

    modport master (
        output cmd_timestamp, cmd_freq, cmd_phase, cmd_amp, cmd_offset, cmd_valid,
        input  cmd_ready, m_axis_phase_tdata, m_axis_phase_tvalid, amp_out, offset_out
    );

    modport slave (
        input  cmd_timestamp, cmd_freq, cmd_phase, cmd_amp, cmd_offset, cmd_valid,
        output cmd_ready, m_axis_phase_tdata, m_axis_phase_tvalid, amp_out, offset_out
    );
endinterface

// File: rtl/rfdc_dds_phase_scheduler.sv
// ---------------------------------------------------------------------------
// rfdc_dds_phase_scheduler
// Timed parameter sequencer for a LANES-wide parallel DDS bank. Timestamped
// profile commands (freq/phase/amp/offset) are queued in a FIFO and each one is
// applied at the cycle where the internal time counter equals its timestamp.
// Once a profile is applied, lane i of every output word is base + i*freq and
// base advances by LANES*freq per clock, so phase is continuous sample to
// sample. amp/offset change in the same cycle as the first word of a profile.
//
// Ports
//   CLK100MHz    in   system clock, rising edge
//   reset        in   synchronous, active-high
//   time_clear   in   forces now to 0 on the next cycle
//   error_clear  in   clears late_error (a simultaneous set wins)
//   bus          slave modport of rfdc_dds_phase_scheduler_if (commands + stream)
//   now          out  free-running time counter
//   fifo_count   out  number of queued commands (staged one excluded)
//   late_error   out  sticky: a command reached WAIT after its timestamp
//   fsm_state    out  current FSM state (IDLE=0, FETCH=1, WAIT=2, APPLY=3)
//
// Build option
//   RFDC_DDS_SCHED_DROP_LATE_EN : late commands are discarded instead of being
//   applied immediately; outputs keep the previous profile.
// ---------------------------------------------------------------------------
module rfdc_dds_phase_scheduler #(
    parameter int LANES      = 16,
    parameter int PHASE_W    = 40,
    parameter int TS_W       = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         CLK100MHz,
    input  logic                         reset,
    input  logic                         time_clear,
    input  logic                         error_clear,
    rfdc_dds_phase_scheduler_if.slave    bus,
    output logic [TS_W-1:0]              now,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         late_error,
    output logic [1:0]                   fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        APPLY = 2'd3
    } state_t;

    state_t state;
    assign fsm_state = state;

    // ---------------- time counter ----------------
    logic [TS_W-1:0] now_next;
    assign now_next = time_clear ? '0 : now + TS_W'(1);

    always_ff @(posedge CLK100MHz) begin
        if (reset) now <= '0;
        else       now <= now_next;
    end

    // ---------------- command FIFO ----------------
    logic [TS_W-1:0]    mem_ts     [FIFO_DEPTH];
    logic [PHASE_W-1:0] mem_freq   [FIFO_DEPTH];
    logic [PHASE_W-1:0] mem_phase  [FIFO_DEPTH];
    logic [13:0]        mem_amp    [FIFO_DEPTH];
    logic [13:0]        mem_offset [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_next;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    assign push       = bus.cmd_valid && bus.cmd_ready;
    assign fifo_empty = (fifo_count == '0);
    assign count_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge CLK100MHz) begin
        if (push) begin
            mem_ts[wr_ptr]     <= bus.cmd_timestamp;
            mem_freq[wr_ptr]   <= bus.cmd_freq;
            mem_phase[wr_ptr]  <= bus.cmd_phase;
            mem_amp[wr_ptr]    <= bus.cmd_amp;
            mem_offset[wr_ptr] <= bus.cmd_offset;
        end
    end

    // cmd_ready is registered from the next count so it is exactly !full.
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            bus.cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count    <= count_next;
            bus.cmd_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
        end
    end

    // ---------------- staging and scheduling ----------------
    logic [TS_W-1:0]    ts_s;
    logic [PHASE_W-1:0] freq_s;
    logic [PHASE_W-1:0] phase_s;
    logic [PHASE_W-1:0] step_s;
    logic [13:0]        amp_s;
    logic [13:0]        offset_s;
    logic [PHASE_W-1:0] off_s [LANES];

    // APPLY is the cycle where now == ts, so WAIT looks one cycle ahead using
    // now_next (this also lets a time_clear retarget a waiting command). A
    // command still in WAIT when now has reached ts can no longer make it and
    // counts as late. A pending time_clear suppresses the late decision since
    // time is about to restart.
    logic due;
    logic late;
    assign due  = (now_next == ts_s);
    assign late = !due && !time_clear && (now >= ts_s);

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            APPLY:   pop = !fifo_empty;
`ifdef RFDC_DDS_SCHED_DROP_LATE_EN
            WAIT:    pop = late && !fifo_empty;
`endif
            default: pop = 1'b0;
        endcase
    end

    // ---------------- active profile and datapath ----------------
    logic [PHASE_W-1:0] base;
    logic [PHASE_W-1:0] step;
    logic [PHASE_W-1:0] off [LANES];
    logic [13:0]        amp_d;
    logic [13:0]        offset_d;
    logic               active;

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            state                   <= IDLE;
            ts_s                    <= '0;
            freq_s                  <= '0;
            phase_s                 <= '0;
            step_s                  <= '0;
            amp_s                   <= '0;
            offset_s                <= '0;
            base                    <= '0;
            step                    <= '0;
            amp_d                   <= '0;
            offset_d                <= '0;
            active                  <= 1'b0;
            late_error              <= 1'b0;
            bus.m_axis_phase_tdata  <= '0;
            bus.m_axis_phase_tvalid <= 1'b0;
            bus.amp_out             <= '0;
            bus.offset_out          <= '0;
            for (int i = 0; i < LANES; i++) begin
                off_s[i] <= '0;
                off[i]   <= '0;
            end
        end else begin
            // Head of FIFO moves into staging whenever it is popped.
            if (pop) begin
                ts_s     <= mem_ts[rd_ptr];
                freq_s   <= mem_freq[rd_ptr];
                phase_s  <= mem_phase[rd_ptr];
                amp_s    <= mem_amp[rd_ptr];
                offset_s <= mem_offset[rd_ptr];
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= FETCH;
                end
                FETCH: begin
                    for (int i = 0; i < LANES; i++) begin
                        off_s[i] <= PHASE_W'(i) * freq_s;
                    end
                    step_s <= PHASE_W'(LANES) * freq_s;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (due) begin
                        state <= APPLY;
                    end else if (late) begin
`ifdef RFDC_DDS_SCHED_DROP_LATE_EN
                        state <= fifo_empty ? IDLE : FETCH;
`else
                        state <= APPLY;
`endif
                    end
                end
                APPLY: begin
                    state <= fifo_empty ? IDLE : FETCH;
                end
                default: state <= IDLE;
            endcase

            if (state == WAIT && late) late_error <= 1'b1;
            else if (error_clear)      late_error <= 1'b0;

            // Free-running phase accumulator; a new profile overrides the
            // accumulator state at the APPLY boundary.
            if (active) begin
                for (int i = 0; i < LANES; i++) begin
                    bus.m_axis_phase_tdata[PHASE_W*i +: PHASE_W] <= base + off[i];
                end
                base <= base + step;
            end
            bus.m_axis_phase_tvalid <= active;
            bus.amp_out             <= amp_d;
            bus.offset_out          <= offset_d;

            if (state == APPLY) begin
                base     <= phase_s;
                step     <= step_s;
                amp_d    <= amp_s;
                offset_d <= offset_s;
                active   <= 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    off[i] <= off_s[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_rfdc_dds_phase_scheduler.sv
module tb_rfdc_dds_phase_scheduler;
    localparam int LANES      = 16;
    localparam int PHASE_W    = 40;
    localparam int TS_W       = 64;
    localparam int FIFO_DEPTH = 16;
    localparam int DW         = LANES * PHASE_W;

    logic            CLK100MHz = 1'b0;
    logic            reset = 1'b1;
    logic            time_clear = 1'b0;
    logic            error_clear = 1'b0;
    logic [TS_W-1:0] now;
    logic [4:0]      fifo_count;
    logic            late_error;
    logic [1:0]      fsm_state;

    rfdc_dds_phase_scheduler_if #(.LANES(LANES), .PHASE_W(PHASE_W), .TS_W(TS_W)) bus ();

    rfdc_dds_phase_scheduler #(
        .LANES(LANES), .PHASE_W(PHASE_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK100MHz  (CLK100MHz),
        .reset      (reset),
        .time_clear (time_clear),
        .error_clear(error_clear),
        .bus        (bus),
        .now        (now),
        .fifo_count (fifo_count),
        .late_error (late_error),
        .fsm_state  (fsm_state)
    );

    always #5 CLK100MHz = ~CLK100MHz;

    int checks   = 0;
    int failures = 0;

    // Reference model: list of applied profiles (apply time = now value of the
    // APPLY cycle). The word visible at now=n comes from the latest profile
    // with apply time <= n-2 and equals phase + (16*(n-2-at) + i)*freq.
    logic [TS_W-1:0]    prof_at    [$];
    logic [PHASE_W-1:0] prof_phase [$];
    logic [PHASE_W-1:0] prof_freq  [$];
    logic [13:0]        prof_amp   [$];
    logic [13:0]        prof_off   [$];

    typedef struct {
        logic [PHASE_W-1:0] freq;
        logic [PHASE_W-1:0] phase;
        logic [13:0]        amp;
        logic [13:0]        offset;
        logic [PHASE_W-1:0] lane0;
        logic [PHASE_W-1:0] lane1;
        logic [PHASE_W-1:0] lane15;
        logic [PHASE_W-1:0] next0;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s now=%0d got=%h exp=%h", nm, now, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK100MHz);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        time_clear    = 1'b0;
        error_clear   = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        prof_at.delete();
        prof_phase.delete();
        prof_freq.delete();
        prof_amp.delete();
        prof_off.delete();
    endtask

    task automatic wait_now(input logic [TS_W-1:0] target);
        int n;
        n = 0;
        while (now != target && n < 3000) begin
            tick();
            n++;
        end
        if (now != target) begin
            checks++;
            failures++;
            $display("FAIL wait_now timeout now=%0d target=%0d", now, target);
        end
    endtask

    task automatic push(input logic [TS_W-1:0] ts, input logic [PHASE_W-1:0] fr,
                        input logic [PHASE_W-1:0] ph, input logic [13:0] am, input logic [13:0] of);
        bus.cmd_timestamp = ts;
        bus.cmd_freq      = fr;
        bus.cmd_phase     = ph;
        bus.cmd_amp       = am;
        bus.cmd_offset    = of;
        bus.cmd_valid     = 1'b1;
        tick();
        bus.cmd_valid     = 1'b0;
    endtask

    task automatic model_add(input logic [TS_W-1:0] at, input logic [PHASE_W-1:0] fr,
                             input logic [PHASE_W-1:0] ph, input logic [13:0] am, input logic [13:0] of);
        prof_at.push_back(at);
        prof_freq.push_back(fr);
        prof_phase.push_back(ph);
        prof_amp.push_back(am);
        prof_off.push_back(of);
    endtask

    function automatic logic [DW-1:0] model_word(input logic [PHASE_W-1:0] ph,
                                                 input logic [PHASE_W-1:0] fr,
                                                 input logic [TS_W-1:0] k);
        logic [DW-1:0]      w;
        logic [PHASE_W-1:0] mult;
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            mult = PHASE_W'(k * LANES + TS_W'(i));
            w[i*PHASE_W +: PHASE_W] = ph + mult * fr;
        end
        return w;
    endfunction

    task automatic run_check(input string nm, input logic [TS_W-1:0] until_now);
        int            p;
        int            guard;
        logic          ev;
        logic [DW-1:0] ew;
        logic [27:0]   eao;
        guard = 0;
        while (now < until_now && guard < 4000) begin
            p = -1;
            foreach (prof_at[j]) if (prof_at[j] + 2 <= now) p = j;
            if (p < 0) begin
                ev  = 1'b0;
                ew  = '0;
                eao = '0;
            end else begin
                ev  = 1'b1;
                ew  = model_word(prof_phase[p], prof_freq[p], now - prof_at[p] - 2);
                eao = {prof_amp[p], prof_off[p]};
            end
            chk({nm, "_tvalid"}, DW'(bus.m_axis_phase_tvalid), DW'(ev));
            chk({nm, "_tdata"}, bus.m_axis_phase_tdata, ew);
            chk({nm, "_amp_off"}, DW'({bus.amp_out, bus.offset_out}), DW'(eao));
            tick();
            guard++;
        end
    endtask

    initial begin
        logic [TS_W-1:0]    ts;
        logic [PHASE_W-1:0] fr;
        logic [PHASE_W-1:0] ph;
        int                 quiet_bad;

        vecs[0] = '{40'h0100000000, 40'h0000000000, 14'd1000, 14'd10,
                    40'h0000000000, 40'h0100000000, 40'h0F00000000, 40'h1000000000};
        vecs[1] = '{40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 14'd16383, 14'd16383,
                    40'hFFFFFFFFFF, 40'hFFFFFFFFFE, 40'hFFFFFFFFF0, 40'hFFFFFFFFEF};
        vecs[2] = '{40'h0000000001, 40'h8000000000, 14'd1, 14'd8191,
                    40'h8000000000, 40'h8000000001, 40'h800000000F, 40'h8000000010};
        vecs[3] = '{40'h1234567890, 40'h0000000010, 14'd4660, 14'd22,
                    40'h0000000010, 40'h12345678A0, 40'h1111111080, 40'h2345678910};

        bus.cmd_timestamp = '0;
        bus.cmd_freq      = '0;
        bus.cmd_phase     = '0;
        bus.cmd_amp       = '0;
        bus.cmd_offset    = '0;
        bus.cmd_valid     = 1'b0;

        // ---- reset state ----
        do_reset();
        chk("rst_now", DW'(now), DW'(0));
        chk("rst_count", DW'(fifo_count), DW'(0));
        chk("rst_ready", DW'(bus.cmd_ready), DW'(1));
        chk("rst_tvalid", DW'(bus.m_axis_phase_tvalid), DW'(0));
        chk("rst_tdata", bus.m_axis_phase_tdata, '0);
        chk("rst_amp_off", DW'({bus.amp_out, bus.offset_out}), DW'(0));
        chk("rst_late", DW'(late_error), DW'(0));

        // ---- table: single command at ts=20, first word at now=22 ----
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push(64'd20, vecs[v].freq, vecs[v].phase, vecs[v].amp, vecs[v].offset);
            wait_now(64'd21);
            chk("tbl_tvalid_pre", DW'(bus.m_axis_phase_tvalid), DW'(0));
            tick();
            chk("tbl_tvalid", DW'(bus.m_axis_phase_tvalid), DW'(1));
            chk("tbl_lane0", DW'(bus.m_axis_phase_tdata[0 +: PHASE_W]), DW'(vecs[v].lane0));
            chk("tbl_lane1", DW'(bus.m_axis_phase_tdata[PHASE_W +: PHASE_W]), DW'(vecs[v].lane1));
            chk("tbl_lane15", DW'(bus.m_axis_phase_tdata[15*PHASE_W +: PHASE_W]), DW'(vecs[v].lane15));
            chk("tbl_amp", DW'(bus.amp_out), DW'(vecs[v].amp));
            chk("tbl_offset", DW'(bus.offset_out), DW'(vecs[v].offset));
            tick();
            chk("tbl_next0", DW'(bus.m_axis_phase_tdata[0 +: PHASE_W]), DW'(vecs[v].next0));
        end

        // ---- two profiles: switch at now=102 ----
        do_reset();
        push(64'd50, 40'h0000123457, 40'h0000000100, 14'd100, 14'd5);
        push(64'd100, 40'h0200000003, 40'h8000000000, 14'd9000, 14'd16000);
        model_add(64'd50, 40'h0000123457, 40'h0000000100, 14'd100, 14'd5);
        model_add(64'd100, 40'h0200000003, 40'h8000000000, 14'd9000, 14'd16000);
        run_check("two", 64'd102);
        chk("two_lane0_switch", DW'(bus.m_axis_phase_tdata[0 +: PHASE_W]), DW'(40'h8000000000));
        chk("two_amp_switch", DW'(bus.amp_out), DW'(14'd9000));
        chk("two_off_switch", DW'(bus.offset_out), DW'(14'd16000));
        run_check("two", 64'd120);

        // ---- late command: ts=5 pushed at now=30 ----
        do_reset();
        wait_now(64'd30);
        push(64'd5, 40'h0000000ABC, 40'h0000001234, 14'd77, 14'd88);
        wait_now(64'd32);
        error_clear = 1'b1;
        wait_now(64'd33);
        chk("late_pre", DW'(late_error), DW'(0));
        tick();
        chk("late_set_wins", DW'(late_error), DW'(1));
        tick();
        chk("late_cleared", DW'(late_error), DW'(0));
        error_clear = 1'b0;
        chk("late_tvalid_35", DW'(bus.m_axis_phase_tvalid), DW'(0));
        tick();
`ifdef RFDC_DDS_SCHED_DROP_LATE_EN
        chk("late_dropped_tvalid", DW'(bus.m_axis_phase_tvalid), DW'(0));
        chk("late_dropped_tdata", bus.m_axis_phase_tdata, '0);
`else
        chk("late_applied_tvalid", DW'(bus.m_axis_phase_tvalid), DW'(1));
        chk("late_applied_lane0", DW'(bus.m_axis_phase_tdata[0 +: PHASE_W]), DW'(40'h0000001234));
        chk("late_applied_amp", DW'(bus.amp_out), DW'(14'd77));
`endif

        // ---- FIFO fill: 17 pushes, one staged, 16 queued, 18th refused ----
        do_reset();
        for (int k = 0; k < 17; k++) begin
            ts = 64'd40 + 64'(3 * k);
            fr = 40'h0000010000 + PHASE_W'(k * 977);
            ph = PHASE_W'(k) << 32;
            push(ts, fr, ph, 14'(k + 1), 14'(200 + k));
            model_add(ts, fr, ph, 14'(k + 1), 14'(200 + k));
            if (k == 15) begin
                chk("fifo_count15", DW'(fifo_count), DW'(15));
                chk("fifo_ready15", DW'(bus.cmd_ready), DW'(1));
            end
        end
        chk("fifo_count16", DW'(fifo_count), DW'(16));
        chk("fifo_full_ready", DW'(bus.cmd_ready), DW'(0));
        push(64'd91, 40'h7777777777, 40'h3333333333, 14'd999, 14'd999);
        chk("fifo_no_overwrite_count", DW'(fifo_count), DW'(16));
        run_check("fifo", 64'd110);

        // ---- time_clear while waiting ----
        do_reset();
        push(64'd15, 40'h0000000010, 40'h0000000055, 14'd1, 14'd2);
        wait_now(64'd10);
        time_clear = 1'b1;
        tick();
        time_clear = 1'b0;
        chk("tclr_now", DW'(now), DW'(0));
        wait_now(64'd16);
        chk("tclr_tvalid_pre", DW'(bus.m_axis_phase_tvalid), DW'(0));
        tick();
        chk("tclr_tvalid", DW'(bus.m_axis_phase_tvalid), DW'(1));
        chk("tclr_lane0", DW'(bus.m_axis_phase_tdata[0 +: PHASE_W]), DW'(40'h0000000055));
        chk("tclr_lane1", DW'(bus.m_axis_phase_tdata[PHASE_W +: PHASE_W]), DW'(40'h0000000065));
        chk("tclr_late", DW'(late_error), DW'(0));

        // ---- randomized profiles vs reference model ----
        for (int r = 0; r < 2; r++) begin
            do_reset();
            ts = 64'(30 + $urandom_range(0, 10));
            for (int k = 0; k < 10; k++) begin
                fr = {8'($urandom), 32'($urandom)};
                ph = {8'($urandom), 32'($urandom)};
                push(ts, fr, ph, 14'($urandom), 14'($urandom));
                model_add(ts, fr, ph, bus.cmd_amp, bus.cmd_offset);
                ts = ts + 64'($urandom_range(3, 25));
            end
            run_check("rnd", ts + 64'd20);
            chk("rnd_late", DW'(late_error), DW'(0));
        end

        // ---- reset while waiting with 4 queued ----
        do_reset();
        push(64'd10, 40'h0000000077, 40'h0000000001, 14'd3, 14'd4);
        for (int k = 0; k < 5; k++) begin
            push(64'(500 + k), 40'h0000000100, 40'h0000000002, 14'd5, 14'd6);
        end
        wait_now(64'd60);
        chk("rstw_count_before", DW'(fifo_count), DW'(4));
        chk("rstw_tvalid_before", DW'(bus.m_axis_phase_tvalid), DW'(1));
        reset = 1'b1;
        tick();
        chk("rstw_count", DW'(fifo_count), DW'(0));
        chk("rstw_tvalid", DW'(bus.m_axis_phase_tvalid), DW'(0));
        chk("rstw_tdata", bus.m_axis_phase_tdata, '0);
        chk("rstw_amp_off", DW'({bus.amp_out, bus.offset_out}), DW'(0));
        reset = 1'b0;
        quiet_bad = 0;
        for (int c = 0; c < 530; c++) begin
            if (bus.m_axis_phase_tvalid !== 1'b0 || bus.m_axis_phase_tdata !== '0) quiet_bad++;
            tick();
        end
        chk("rstw_quiet_after", DW'(quiet_bad), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
